sdram_read_arbiter: RTL and testbench

- Round-robin scheduler that shares the single SDRAM read channel (the AVMM read wrapper's read_addr/read_cnt/read_start/read_valid/read_data/read_done handshake) between N_REQ NPU clients: weight loader, activation loader and instruction fetch.
- Captures each client's request, serialises them onto the channel one at a time, and routes returned beats and the completion pulse back to the owning client.
- Sits between the NPU load engines and the SDRAM read wrapper.

---
 rtl/sdram_read_arbiter.sv | 174 +++++++++++++++++
 tb/tb_sdram_read_arbiter.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_read_arbiter.sv
// Round-robin arbiter sharing one SDRAM read channel between N_REQ load clients.
// Optional WAIT watchdog with sticky timeout_err port: define SDRAM_READ_ARB_TIMEOUT_EN.
module sdram_read_arbiter #(
    parameter int N_REQ          = 3,
    parameter int ADDR_W         = 32,
    parameter int CNT_W          = 11,
    parameter int DATA_W         = 128,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ*ADDR_W-1:0] req_addr,
    input  logic [N_REQ*CNT_W-1:0]  req_cnt,
    input  logic [N_REQ-1:0]        req_start,
    output logic [N_REQ-1:0]        req_busy,
    output logic [N_REQ-1:0]        req_valid,
    output logic [DATA_W-1:0]       req_data,
    output logic [N_REQ-1:0]        req_done,
    output logic [N_REQ-1:0]        req_err,
    output logic [ADDR_W-1:0]       rd_addr,
    output logic [CNT_W-1:0]        rd_cnt,
    output logic                    rd_start,
    input  logic                    rd_valid,
    input  logic [DATA_W-1:0]       rd_data,
    input  logic                    rd_done
`ifdef SDRAM_READ_ARB_TIMEOUT_EN
    ,
    output logic                    timeout_err
`endif
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [N_REQ-1:0] ONE = N_REQ'(1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    state_t             r_state;
    logic [N_REQ-1:0]   r_pend;
    logic [N_REQ-1:0]   r_err;
    logic [N_REQ-1:0]   r_done;
    logic [ADDR_W-1:0]  r_addr [N_REQ];
    logic [CNT_W-1:0]   r_cnt  [N_REQ];
    logic [PTR_W-1:0]   r_ptr;
    logic [PTR_W-1:0]   r_grant;
    logic               r_rd_start;
    logic [ADDR_W-1:0]  r_rd_addr;
    logic [CNT_W-1:0]   r_rd_cnt;

    logic               w_found;
    logic [PTR_W-1:0]   w_win;
    int                 w_idx;
    logic [N_REQ-1:0]   w_valid;

`ifdef SDRAM_READ_ARB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0]   r_tmo;
    logic               r_timeout_err;
    assign timeout_err = r_timeout_err;
`endif

    // Request capture; a start while still pending is refused and flagged.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend <= '0;
            r_err  <= '0;
            for (int i = 0; i < N_REQ; i++) begin
                r_addr[i] <= '0;
                r_cnt[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (req_start[i]) begin
                    if (r_pend[i]) begin
                        r_err[i] <= 1'b1;
                    end else begin
                        r_pend[i] <= 1'b1;
                        r_addr[i] <= req_addr[i*ADDR_W +: ADDR_W];
                        r_cnt[i]  <= req_cnt[i*CNT_W +: CNT_W];
                    end
                end
                if (r_state == S_DONE && r_grant == PTR_W'(i))
                    r_pend[i] <= 1'b0;
            end
        end
    end

    // First pending requester at or above the round-robin pointer, wrapping.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = 0;
        for (int k = 0; k < N_REQ; k++) begin
            w_idx = (int'(r_ptr) + k) % N_REQ;
            if (!w_found && r_pend[w_idx]) begin
                w_found = 1'b1;
                w_win   = PTR_W'(w_idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_ptr      <= '0;
            r_grant    <= '0;
            r_rd_start <= 1'b0;
            r_rd_addr  <= '0;
            r_rd_cnt   <= '0;
            r_done     <= '0;
`ifdef SDRAM_READ_ARB_TIMEOUT_EN
            r_tmo         <= '0;
            r_timeout_err <= 1'b0;
`endif
        end else begin
            r_rd_start <= 1'b0;
            r_done     <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_grant   <= w_win;
                        r_rd_addr <= r_addr[w_win];
                        r_rd_cnt  <= r_cnt[w_win];
                        // Zero-length requests complete without touching SDRAM.
                        if (r_cnt[w_win] != '0) begin
                            r_rd_start <= 1'b1;
                            r_state    <= S_WAIT;
`ifdef SDRAM_READ_ARB_TIMEOUT_EN
                            r_tmo      <= '0;
`endif
                        end else begin
                            r_state <= S_DONE;
                        end
                    end
                end
                S_WAIT: begin
                    if (rd_done) begin
                        r_state <= S_DONE;
                    end
`ifdef SDRAM_READ_ARB_TIMEOUT_EN
                    else if (r_tmo == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                        r_state       <= S_DONE;
                        r_timeout_err <= 1'b1;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
`endif
                end
                S_DONE: begin
                    r_done  <= ONE << r_grant;
                    r_ptr   <= (r_grant == PTR_W'(N_REQ - 1)) ? '0 : r_grant + 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Beats are steered only while a granted burst is outstanding.
    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_valid
            assign w_valid[gi] = rd_valid && (r_state == S_WAIT) && (r_grant == PTR_W'(gi));
        end
    endgenerate

    assign req_valid = w_valid;
    assign req_data  = rd_data;
    assign req_busy  = r_pend;
    assign req_done  = r_done;
    assign req_err   = r_err;
    assign rd_addr   = r_rd_addr;
    assign rd_cnt    = r_rd_cnt;
    assign rd_start  = r_rd_start;

endmodule

// File: tb/tb_sdram_read_arbiter.sv
// Bench for sdram_read_arbiter: vector table of request groups plus hand-written
// latency, busy, reset and (with SDRAM_READ_ARB_TIMEOUT_EN) watchdog sequences.
module tb_sdram_read_arbiter;
    localparam int N   = 3;
    localparam int AW  = 32;
    localparam int CW  = 11;
    localparam int DW  = 128;
    localparam int TMO = 64;

    logic            clk = 1'b0;
    logic            rst;
    logic [N*AW-1:0] req_addr;
    logic [N*CW-1:0] req_cnt;
    logic [N-1:0]    req_start;
    logic [N-1:0]    req_busy, req_valid, req_done, req_err;
    logic [DW-1:0]   req_data;
    logic [AW-1:0]   rd_addr;
    logic [CW-1:0]   rd_cnt;
    logic            rd_start, rd_valid, rd_done;
    logic [DW-1:0]   rd_data;
`ifdef SDRAM_READ_ARB_TIMEOUT_EN
    logic            timeout_err;
`endif

    always #5 clk = ~clk;

    sdram_read_arbiter #(.N_REQ(N), .ADDR_W(AW), .CNT_W(CW), .DATA_W(DW), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst),
        .req_addr(req_addr), .req_cnt(req_cnt), .req_start(req_start),
        .req_busy(req_busy), .req_valid(req_valid), .req_data(req_data),
        .req_done(req_done), .req_err(req_err),
        .rd_addr(rd_addr), .rd_cnt(rd_cnt), .rd_start(rd_start),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_done(rd_done)
`ifdef SDRAM_READ_ARB_TIMEOUT_EN
        , .timeout_err(timeout_err)
`endif
    );

    typedef struct {
        int             idx;
        logic [AW-1:0]  addr;
        logic [CW-1:0]  cnt;
    } txn_t;

    typedef struct {
        logic [N-1:0]          mask;
        logic [N-1:0][AW-1:0]  addr;
        logic [N-1:0][CW-1:0]  cnt;
        logic [2:0][1:0]       order;
        int                    n;
    } vec_t;

    txn_t exp_q[$];
    vec_t vecs[5];

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int cyc_rd_start = 0;
    int cyc_done = 0;
    int n_rd_start = 0;
    int mon_beats = 0;
    bit mon_active = 0;
    bit bfm_busy = 0;
    bit bfm_no_done = 0;
    int t_start = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [N-1:0] onehot(input int i);
        logic [N-1:0] one;
        one = 1;
        return one << i;
    endfunction

    // Read-wrapper model: beat b of a burst carries {burst address, b}.
    initial begin
        logic [AW-1:0] a;
        int n;
        rd_valid = 1'b0;
        rd_done  = 1'b0;
        rd_data  = '0;
        forever begin
            @(negedge clk);
            if (rd_start && !rst) begin
                a = rd_addr;
                n = int'(rd_cnt);
                bfm_busy = 1;
                for (int b = 0; b < n; b++) begin
                    @(posedge clk); #1;
                    rd_valid = 1'b1;
                    rd_data  = {a, 96'(b)};
                end
                @(posedge clk); #1;
                rd_valid = 1'b0;
                if (!bfm_no_done) begin
                    rd_done = 1'b1;
                    @(posedge clk); #1;
                    rd_done = 1'b0;
                end else begin
                    bfm_no_done = 0;
                end
                bfm_busy = 0;
            end
        end
    end

    // Scoreboard monitor: front of exp_q is the transaction expected to be in service.
    always @(negedge clk) begin
        if (rst) begin
            mon_active = 0;
            mon_beats  = 0;
        end else begin
            if (rd_start) begin
                cyc_rd_start = cyc;
                n_rd_start++;
                if (exp_q.size() == 0) begin
                    check("rd_start_unexpected", 128'(rd_start), 128'(0));
                end else begin
                    check("rd_overlap", 128'(mon_active), 128'(0));
                    check("rd_addr", 128'(rd_addr), 128'(exp_q[0].addr));
                    check("rd_cnt", 128'(rd_cnt), 128'(exp_q[0].cnt));
                    mon_active = 1;
                    mon_beats  = 0;
                end
            end
            if (req_valid != '0) begin
                if (exp_q.size() == 0 || !mon_active) begin
                    check("valid_unexpected", 128'(req_valid), 128'(0));
                end else begin
                    check("valid_owner", 128'(req_valid), 128'(onehot(exp_q[0].idx)));
                    check("beat_data", req_data, {exp_q[0].addr, 96'(mon_beats)});
                    mon_beats++;
                end
            end
            if (req_done != '0) begin
                cyc_done = cyc;
                if (exp_q.size() == 0) begin
                    check("done_unexpected", 128'(req_done), 128'(0));
                end else begin
                    check("done_owner", 128'(req_done), 128'(onehot(exp_q[0].idx)));
                    check("done_beats", 128'(mon_beats), 128'(exp_q[0].cnt));
                    check("busy_clear", 128'(req_busy[exp_q[0].idx]), 128'(0));
                    $display("txn req=%0d addr=%h cnt=%0d beats=%0d done_cycle=%0d",
                             exp_q[0].idx, exp_q[0].addr, exp_q[0].cnt, mon_beats, cyc);
                    void'(exp_q.pop_front());
                    mon_active = 0;
                    mon_beats  = 0;
                end
            end
        end
    end

    task automatic push(input int idx, input logic [AW-1:0] a, input logic [CW-1:0] c);
        txn_t t;
        t.idx = idx; t.addr = a; t.cnt = c;
        exp_q.push_back(t);
    endtask

    task automatic send(input logic [N-1:0] m, input logic [N-1:0][AW-1:0] a, input logic [N-1:0][CW-1:0] c);
        @(posedge clk); #1;
        for (int i = 0; i < N; i++) begin
            req_addr[i*AW +: AW] = a[i];
            req_cnt[i*CW +: CW]  = c[i];
        end
        req_start = m;
        t_start   = cyc;
        @(posedge clk); #1;
        req_start = '0;
    endtask

    task automatic send1(input int i, input logic [AW-1:0] a, input logic [CW-1:0] c);
        logic [N-1:0][AW-1:0] aa;
        logic [N-1:0][CW-1:0] cc;
        aa = '0; cc = '0;
        aa[i] = a; cc[i] = c;
        send(onehot(i), aa, cc);
    endtask

    task automatic wait_empty(input string name);
        int k = 0;
        while (exp_q.size() != 0 && k < 3000) begin
            @(posedge clk);
            k++;
        end
        check(name, 128'(exp_q.size()), 128'(0));
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic set_vec(input int v, input logic [N-1:0] m,
                           input logic [AW-1:0] a0, input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                           input logic [CW-1:0] c0, input logic [CW-1:0] c1, input logic [CW-1:0] c2,
                           input int o0, input int o1, input int o2, input int n);
        vecs[v].mask = m;
        vecs[v].addr[0] = a0; vecs[v].addr[1] = a1; vecs[v].addr[2] = a2;
        vecs[v].cnt[0]  = c0; vecs[v].cnt[1]  = c1; vecs[v].cnt[2]  = c2;
        vecs[v].order[0] = 2'(o0); vecs[v].order[1] = 2'(o1); vecs[v].order[2] = 2'(o2);
        vecs[v].n = n;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int k;
        int r;
        int nstart;
        int delta;
        rst = 1'b1; req_addr = '0; req_cnt = '0; req_start = '0;

        // Grant orders follow the round-robin pointer carried from vector to vector.
        set_vec(0, 3'b111, 32'h1000_0000, 32'h1100_0000, 32'h1200_0000, 11'd4, 11'd2, 11'd3, 0, 1, 2, 3);
        set_vec(1, 3'b101, 32'h1300_0000, 32'h0,         32'h1500_0000, 11'd1, 11'd0, 11'd7, 0, 2, 0, 2);
        set_vec(2, 3'b110, 32'h0,         32'h1600_0000, 32'h1700_0000, 11'd0, 11'd5, 11'd1, 1, 2, 0, 2);
        set_vec(3, 3'b011, 32'h1800_0000, 32'h1900_0000, 32'h0,         11'd0, 11'd3, 11'd0, 0, 1, 0, 2);
        set_vec(4, 3'b101, 32'h1A00_0000, 32'h0,         32'h1B00_0000, 11'd2, 11'd0, 11'd6, 2, 0, 0, 2);

        repeat (3) @(posedge clk);
        #1;
        check("reset_rd_start", 128'(rd_start), 128'(0));
        check("reset_rd_addr", 128'(rd_addr), 128'(0));
        check("reset_rd_cnt", 128'(rd_cnt), 128'(0));
        check("reset_busy", 128'(req_busy), 128'(0));
        check("reset_done", 128'(req_done), 128'(0));
        check("reset_err", 128'(req_err), 128'(0));
        rst = 1'b0;
        repeat (2) @(posedge clk);

        for (int v = 0; v < 5; v++) begin
            for (int j = 0; j < vecs[v].n; j++) begin
                r = int'(vecs[v].order[j]);
                push(r, vecs[v].addr[r], vecs[v].cnt[r]);
            end
            send(vecs[v].mask, vecs[v].addr, vecs[v].cnt);
            wait_empty($sformatf("vec%0d_drain", v));
            check($sformatf("vec%0d_busy", v), 128'(req_busy), 128'(0));
            check($sformatf("vec%0d_err", v), 128'(req_err), 128'(0));
        end

        // Single request: rd_start two cycles after the request pulse.
        push(0, 32'h2000_0000, 11'd11);
        send1(0, 32'h2000_0000, 11'd11);
        check("single_busy", 128'(req_busy), 128'(3'b001));
        wait_empty("single_drain");
        check("single_latency", 128'(cyc_rd_start - t_start), 128'(2));

        // Zero count: no downstream access, done three cycles after the request.
        nstart = n_rd_start;
        push(1, 32'h2100_0000, 11'd0);
        send1(1, 32'h2100_0000, 11'd0);
        wait_empty("zero_drain");
        check("zero_latency", 128'(cyc_done - t_start), 128'(3));
        check("zero_no_rd_start", 128'(n_rd_start - nstart), 128'(0));

        // Re-request while busy: refused, flagged sticky, first burst unaffected.
        push(2, 32'h5000_0000, 11'd8);
        send1(2, 32'h5000_0000, 11'd8);
        @(posedge clk); #1;
        send1(2, 32'h6000_0000, 11'd5);
        check("busy_err_set", 128'(req_err), 128'(3'b100));
        wait_empty("busy_drain");
        repeat (10) @(posedge clk);
        #1;
        check("busy_err_sticky", 128'(req_err), 128'(3'b100));
        check("rd_addr_hold", 128'(rd_addr), 128'(32'h5000_0000));

        // Reset in the middle of a 16-beat burst.
        push(0, 32'h3000_0000, 11'd16);
        send1(0, 32'h3000_0000, 11'd16);
        k = 0;
        while (mon_beats < 4 && k < 200) begin
            @(posedge clk);
            k++;
        end
        check("rst_reach_beat", 128'(mon_beats >= 4), 128'(1));
        #1;
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        check("rst_mid_rd_start", 128'(rd_start), 128'(0));
        check("rst_mid_rd_addr", 128'(rd_addr), 128'(0));
        check("rst_mid_rd_cnt", 128'(rd_cnt), 128'(0));
        check("rst_mid_busy", 128'(req_busy), 128'(0));
        check("rst_mid_valid", 128'(req_valid), 128'(0));
        check("rst_mid_done", 128'(req_done), 128'(0));
        check("rst_mid_err", 128'(req_err), 128'(0));
        rst = 1'b0;
        k = 0;
        while (bfm_busy && k < 100) begin
            @(posedge clk);
            k++;
        end
        check("rst_stale_finished", 128'(bfm_busy), 128'(0));
        repeat (2) @(posedge clk);
        push(1, 32'h4000_0000, 11'd3);
        send1(1, 32'h4000_0000, 11'd3);
        wait_empty("rst_after_drain");

`ifdef SDRAM_READ_ARB_TIMEOUT_EN
        // Watchdog: first burst never completes, next pending requester still served.
        begin
            logic [N-1:0][AW-1:0] aa;
            logic [N-1:0][CW-1:0] cc;
            check("tmo_err_clear", 128'(timeout_err), 128'(0));
            bfm_no_done = 1;
            aa = '0; cc = '0;
            aa[0] = 32'h7000_0000; cc[0] = 11'd4;
            aa[1] = 32'h7100_0000; cc[1] = 11'd2;
            push(0, aa[0], cc[0]);
            push(1, aa[1], cc[1]);
            send(3'b011, aa, cc);
            k = 0;
            while (exp_q.size() == 2 && k < 500) begin
                @(posedge clk);
                k++;
            end
            delta = cyc_done - cyc_rd_start;
            check("tmo_fired", 128'(exp_q.size()), 128'(1));
            check("tmo_latency", 128'(delta >= TMO && delta <= TMO + 2), 128'(1));
            #1;
            check("tmo_err_set", 128'(timeout_err), 128'(1));
            wait_empty("tmo_drain");
            check("tmo_err_sticky", 128'(timeout_err), 128'(1));
        end
`endif

        repeat (5) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
